// File: rtl/reg_pkg.sv
// Shared encodings for the context-aware register file: FunSel operations,
// context command opcodes and the context engine state type.
package reg_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_SHR  = 3'b101;
  localparam logic [2:0] FS_LDLZ = 3'b110;
  localparam logic [2:0] FS_LDLS = 3'b111;

  localparam logic CMD_SAVE    = 1'b0;
  localparam logic CMD_RESTORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit register with the full FunSel operation set; a context copy
// load takes priority over the external enable.
module reg_cell
  import reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  input  logic             copy_ld,
  input  logic [WIDTH-1:0] copy_d,
  output logic [WIDTH-1:0] Q
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (copy_ld) begin
      q_d = copy_d;
    end else if (E) begin
      case (FunSel)
        FS_DEC:  q_d = q_q - WIDTH'(1);
        FS_INC:  q_d = q_q + WIDTH'(1);
        FS_LOAD: q_d = I;
        FS_CLR:  q_d = '0;
        FS_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
        FS_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
        FS_LDLZ: q_d = {{(WIDTH-HALF){1'b0}}, I[HALF-1:0]};
        FS_LDLS: q_d = {{(WIDTH-HALF){I[HALF-1]}}, I[HALF-1:0]};
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/reg_file_ctx.sv
// NUM_REG general + NUM_SCR scratch registers with two combinational read
// ports and a context engine that copies one register per cycle between banks.
//
// state   | meaning
// IDLE    | ready for a command; external writes allowed
// COPY    | copying register idx (SAVE: R->S, RESTORE: S->R)
// DONE    | Done pulse, returns to IDLE
module reg_file_ctx
  import reg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 4,
  parameter int NUM_SCR = 4,
  parameter int SELW    = $clog2(NUM_REG + NUM_SCR)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   I,
  input  logic [NUM_REG-1:0] RegSel,
  input  logic [NUM_SCR-1:0] ScrSel,
  input  logic [2:0]         FunSel,
  input  logic [SELW-1:0]    OutASel,
  input  logic [SELW-1:0]    OutBSel,
  output logic [WIDTH-1:0]   OutA,
  output logic [WIDTH-1:0]   OutB,
  input  logic               CmdValid,
  input  logic               CmdOp,
  output logic               CmdReady,
  output logic               Busy,
  output logic               Done
);

  localparam int NUM_ALL = NUM_REG + NUM_SCR;
  localparam int N       = (NUM_REG < NUM_SCR) ? NUM_REG : NUM_SCR;
  localparam int IDXW    = (N > 1) ? $clog2(N) : 1;

  ctx_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             op_q, op_d;
  logic             copy_en;

  logic [WIDTH-1:0] r_q   [NUM_REG];
  logic [WIDTH-1:0] s_q   [NUM_SCR];
  logic [WIDTH-1:0] all_q [NUM_ALL];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= CMD_SAVE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    copy_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          state_d = ST_COPY;
          op_d    = CmdOp;
          idx_d   = '0;
        end
      end
      ST_COPY: begin
        copy_en = 1'b1;
        if (idx_q == IDXW'(N - 1)) state_d = ST_DONE;
        else                       idx_d   = idx_q + IDXW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign CmdReady = (state_q == ST_IDLE);
  assign Busy     = ~CmdReady;
  assign Done     = (state_q == ST_DONE);

  // External enables are gated by CmdReady so the banks are frozen while busy.
  for (genvar k = 0; k < NUM_REG; k++) begin : g_r
    logic             ld;
    logic [WIDTH-1:0] cd;
    if (k < N) begin : g_cp
      assign ld = copy_en & (op_q == CMD_RESTORE) & (idx_q == IDXW'(k));
      assign cd = s_q[k];
    end else begin : g_nc
      assign ld = 1'b0;
      assign cd = '0;
    end
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .Clock   (Clock),
      .Reset   (Reset),
      .E       (RegSel[k] & CmdReady),
      .FunSel  (FunSel),
      .I       (I),
      .copy_ld (ld),
      .copy_d  (cd),
      .Q       (r_q[k])
    );
    assign all_q[k] = r_q[k];
  end

  for (genvar k = 0; k < NUM_SCR; k++) begin : g_s
    logic             ld;
    logic [WIDTH-1:0] cd;
    if (k < N) begin : g_cp
      assign ld = copy_en & (op_q == CMD_SAVE) & (idx_q == IDXW'(k));
      assign cd = r_q[k];
    end else begin : g_nc
      assign ld = 1'b0;
      assign cd = '0;
    end
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .Clock   (Clock),
      .Reset   (Reset),
      .E       (ScrSel[k] & CmdReady),
      .FunSel  (FunSel),
      .I       (I),
      .copy_ld (ld),
      .copy_d  (cd),
      .Q       (s_q[k])
    );
    assign all_q[NUM_REG + k] = s_q[k];
  end

  // Unmatched selects fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int i = 0; i < NUM_ALL; i++) begin
      if (OutASel == SELW'(i)) OutA = all_q[i];
      if (OutBSel == SELW'(i)) OutB = all_q[i];
    end
  end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Bench for reg_file_ctx: default 4+4x32 instance checked every cycle against
// a bank-level model, plus a 16-bit 8+2 instance checked with literal vectors.
module tb_reg_file_ctx;
  import reg_pkg::*;

  logic        Clock, Reset;
  logic [31:0] I;
  logic [3:0]  RegSel, ScrSel;
  logic [2:0]  FunSel, OutASel, OutBSel;
  logic [31:0] OutA, OutB;
  logic        CmdValid, CmdOp, CmdReady, Busy, Done;

  logic [15:0] I2;
  logic [7:0]  RegSel2;
  logic [1:0]  ScrSel2;
  logic [2:0]  FunSel2;
  logic [3:0]  OutASel2, OutBSel2;
  logic [15:0] OutA2, OutB2;
  logic        CmdValid2, CmdOp2, CmdReady2, Busy2, Done2;

  reg_file_ctx dut (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .ScrSel(ScrSel),
    .FunSel(FunSel), .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA),
    .OutB(OutB), .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdReady(CmdReady),
    .Busy(Busy), .Done(Done)
  );

  reg_file_ctx #(.WIDTH(16), .NUM_REG(8), .NUM_SCR(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .I(I2), .RegSel(RegSel2), .ScrSel(ScrSel2),
    .FunSel(FunSel2), .OutASel(OutASel2), .OutBSel(OutBSel2), .OutA(OutA2),
    .OutB(OutB2), .CmdValid(CmdValid2), .CmdOp(CmdOp2), .CmdReady(CmdReady2),
    .Busy(Busy2), .Done(Done2)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic chk_en = 1'b0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bank-level model: age counts cycles since acceptance (0 = idle,
  // 1..4 = copying register age-1, 5 = Done cycle).
  localparam int NC = 4;
  logic [31:0] rm [4];
  logic [31:0] sm [4];
  int          age;
  logic        mop;

  function automatic logic [31:0] fs_apply(input logic [2:0] fs, input logic [31:0] v,
                                           input logic [31:0] d);
    logic [31:0] lo;
    lo = d % 32'd65536;
    case (fs)
      3'd0:    return v - 32'd1;
      3'd1:    return v + 32'd1;
      3'd2:    return d;
      3'd3:    return 32'd0;
      3'd4:    return v * 32'd2;
      3'd5:    return v / 32'd2;
      3'd6:    return lo;
      default: return (lo >= 32'd32768) ? lo + 32'hFFFF0000 : lo;
    endcase
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        rm[k] <= 32'd0;
        sm[k] <= 32'd0;
      end
      age <= 0;
      mop <= 1'b0;
    end else if (age == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (RegSel[k]) rm[k] <= fs_apply(FunSel, rm[k], I);
        if (ScrSel[k]) sm[k] <= fs_apply(FunSel, sm[k], I);
      end
      if (CmdValid) begin
        age <= 1;
        mop <= CmdOp;
      end
    end else if (age <= NC) begin
      if (mop == 1'b0) sm[age-1] <= rm[age-1];
      else             rm[age-1] <= sm[age-1];
      age <= age + 1;
    end else begin
      age <= 0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] sel);
    if (sel < 3'd4) return rm[sel[1:0]];
    return sm[sel[1:0]];
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      check("outa", OutA, exp_rd(OutASel));
      check("outb", OutB, exp_rd(OutBSel));
      check("ready", {31'd0, CmdReady}, {31'd0, age == 0});
      check("busy", {31'd0, Busy}, {31'd0, age != 0});
      check("done", {31'd0, Done}, {31'd0, age == NC + 1});
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input logic port_b, input int sel, input string nm, input logic [31:0] exp);
    if (port_b) OutBSel = sel[2:0];
    else        OutASel = sel[2:0];
    #1;
    check(nm, port_b ? OutB : OutA, exp);
  endtask

  task automatic rd2(input int sel, input string nm, input logic [15:0] exp);
    OutASel2 = sel[3:0];
    #1;
    check(nm, {16'd0, OutA2}, {16'd0, exp});
  endtask

  logic [2:0]  t_fs [8];
  logic [31:0] t_i  [8];
  logic [31:0] t_st [8];
  logic [31:0] t_ex [8];

  initial begin
    int ready_low, done_at, acc_c, done2_at, dones;

    t_fs[0] = FS_SHL;  t_i[0] = 32'hA5A5A5A5; t_st[0] = 32'h80000001; t_ex[0] = 32'h00000002;
    t_fs[1] = FS_SHR;  t_i[1] = 32'hA5A5A5A5; t_st[1] = 32'h80000001; t_ex[1] = 32'h40000000;
    t_fs[2] = FS_CLR;  t_i[2] = 32'hA5A5A5A5; t_st[2] = 32'h00001234; t_ex[2] = 32'h00000000;
    t_fs[3] = FS_LDLS; t_i[3] = 32'h00008001; t_st[3] = 32'h00000000; t_ex[3] = 32'hFFFF8001;
    t_fs[4] = FS_LDLZ; t_i[4] = 32'h00008001; t_st[4] = 32'hFFFFFFFF; t_ex[4] = 32'h00008001;
    t_fs[5] = FS_LDLS; t_i[5] = 32'h12347FFF; t_st[5] = 32'hFFFFFFFF; t_ex[5] = 32'h00007FFF;
    t_fs[6] = FS_DEC;  t_i[6] = 32'hA5A5A5A5; t_st[6] = 32'h00000000; t_ex[6] = 32'hFFFFFFFF;
    t_fs[7] = FS_INC;  t_i[7] = 32'hA5A5A5A5; t_st[7] = 32'h00000007; t_ex[7] = 32'h00000008;

    Reset = 1'b1; I = '0; RegSel = '0; ScrSel = '0; FunSel = FS_DEC;
    OutASel = '0; OutBSel = '0; CmdValid = 1'b0; CmdOp = 1'b0;
    I2 = '0; RegSel2 = '0; ScrSel2 = '0; FunSel2 = FS_DEC;
    OutASel2 = '0; OutBSel2 = '0; CmdValid2 = 1'b0; CmdOp2 = 1'b0;

    #3 Reset = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_ready", {31'd0, CmdReady}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_outa", OutA, 32'd0);
    tick; tick;
    Reset = 1'b1;

    // Load R0, read back on both ports
    RegSel = 4'b0001; FunSel = FS_LOAD; I = 32'hDEADBEEF;
    OutBSel = 3'd5;
    tick;
    RegSel = '0;
    rd(1'b0, 0, "load_r0", 32'hDEADBEEF);
    rd(1'b1, 5, "s1_zero", 32'd0);

    // Wrap-around at all-ones / zero
    RegSel = 4'b0001; FunSel = FS_LOAD; I = 32'hFFFFFFFF; tick;
    FunSel = FS_INC; tick;
    rd(1'b0, 0, "inc_wrap", 32'h00000000);
    FunSel = FS_DEC; tick;
    RegSel = '0;
    rd(1'b0, 0, "dec_wrap", 32'hFFFFFFFF);

    // Operation table applied to R1 and S2 together
    for (int v = 0; v < 8; v++) begin
      RegSel = 4'b0010; ScrSel = 4'b0100; FunSel = FS_LOAD; I = t_st[v];
      tick;
      FunSel = t_fs[v]; I = t_i[v];
      tick;
      RegSel = '0; ScrSel = '0;
      rd(1'b0, 1, "op_r1", t_ex[v]);
      rd(1'b1, 6, "op_s2", t_ex[v]);
    end
    rd(1'b0, 0, "r0_hold", 32'hFFFFFFFF);

    // SAVE accepted together with an increment of R0
    FunSel = FS_LOAD;
    for (int k = 0; k < 4; k++) begin
      RegSel = 4'(1 << k); I = 32'(k + 1);
      tick;
    end
    RegSel = 4'b0001; FunSel = FS_INC; CmdValid = 1'b1; CmdOp = CMD_SAVE;
    tick;
    RegSel = '0; CmdValid = 1'b0;
    ready_low = 0; done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      if (!CmdReady) ready_low++;
      if (Done && done_at == 0) done_at = c;
      tick;
    end
    check("save_ready_low", 32'(ready_low), 32'd5);
    check("save_done_at", 32'(done_at), 32'd5);
    check("save_busy_end", {31'd0, Busy}, 32'd0);
    rd(1'b0, 4, "save_s0", 32'd2);
    rd(1'b0, 5, "save_s1", 32'd2);
    rd(1'b0, 6, "save_s2", 32'd3);
    rd(1'b0, 7, "save_s3", 32'd4);

    // RESTORE with writes attempted while busy and a SAVE held pending
    FunSel = FS_LOAD;
    for (int k = 0; k < 4; k++) begin
      ScrSel = 4'(1 << k); I = 32'hA0 + 32'(k);
      tick;
    end
    ScrSel = '0;
    CmdValid = 1'b1; CmdOp = CMD_RESTORE;
    tick;
    CmdOp = CMD_SAVE; RegSel = 4'hF; FunSel = FS_CLR;
    done_at = 0; acc_c = 0; done2_at = 0;
    for (int c = 1; c <= 13; c++) begin
      if (Done && done_at == 0) begin
        done_at = c;
        RegSel = '0;
      end else if (Done && done2_at == 0) begin
        done2_at = c;
      end
      if (done_at != 0 && CmdReady && acc_c == 0) acc_c = c;
      if (acc_c != 0 && c == acc_c + 1) CmdValid = 1'b0;
      tick;
    end
    CmdValid = 1'b0;
    check("rest_done_at", 32'(done_at), 32'd5);
    check("pend_ready_at", 32'(acc_c), 32'd6);
    check("pend_done_at", 32'(done2_at), 32'd11);
    rd(1'b0, 0, "rest_r0", 32'hA0);
    rd(1'b0, 1, "rest_r1", 32'hA1);
    rd(1'b0, 2, "rest_r2", 32'hA2);
    rd(1'b0, 3, "rest_r3", 32'hA3);

    // Reset dropped during the second COPY cycle of a SAVE
    RegSel = 4'b0001; FunSel = FS_LOAD; I = 32'h55;
    tick;
    RegSel = '0; CmdValid = 1'b1; CmdOp = CMD_SAVE;
    tick;
    CmdValid = 1'b0;
    tick;
    Reset = 1'b0;
    rd(1'b0, 0, "abort_r0", 32'd0);
    rd(1'b1, 4, "abort_s0", 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_ready", {31'd0, CmdReady}, 32'd1);
    tick; tick;
    Reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done) dones++;
      tick;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Parameter sweep instance: 16-bit, 8 general, 2 scratch
    FunSel2 = FS_LOAD;
    for (int k = 0; k < 8; k++) begin
      RegSel2 = 8'(1 << k); I2 = 16'h0101 * 16'(k + 1);
      tick;
    end
    RegSel2 = '0; CmdValid2 = 1'b1; CmdOp2 = CMD_SAVE;
    tick;
    CmdValid2 = 1'b0;
    ready_low = 0; done_at = 0;
    for (int c = 1; c <= 6; c++) begin
      if (!CmdReady2) ready_low++;
      if (Done2 && done_at == 0) done_at = c;
      tick;
    end
    check("w16_ready_low", 32'(ready_low), 32'd3);
    check("w16_done_at", 32'(done_at), 32'd3);
    rd2(8, "w16_s0", 16'h0101);
    rd2(9, "w16_s1", 16'h0202);
    rd2(2, "w16_r2", 16'h0303);
    rd2(7, "w16_r7", 16'h0808);
    tick;
    for (int s = 10; s < 16; s++) rd2(s, "w16_oob", 16'h0000);
    tick;
    RegSel2 = 8'h01; FunSel2 = FS_LDLS; I2 = 16'h0080;
    tick;
    RegSel2 = '0;
    rd2(0, "w16_ldls", 16'hFF80);
    tick;

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
